// File: rtl/huffman_decoder.sv
// rtl/huffman_decoder.sv - serial Huffman decoder with small output FIFO
// Purpose: takes one code bit per accepted strobe (MSB first), walks the fixed
//   prefix-code table and pushes each decoded 4-bit symbol into an output FIFO.
// Optional feature macro: HUFFMAN_DEC_STATS_EN (adds Sym_cnt / Err_cnt).
// Ports:
//   Clk_in    in   clock, rising edge
//   n_Rst     in   asynchronous active-low reset
//   Start     in   pulse: clear accumulator/FIFO/Err/counters, enter DECODE
//   Bit_in    in   serial code bit
//   Bit_vld   in   Bit_in valid
//   Bit_rdy   out  bit can be accepted (DECODE and FIFO not full)
//   Rd_en     in   pop FIFO head (ignored when Empty)
//   Data_out  out  FIFO head symbol (0 when Empty)
//   Empty     out  FIFO empty
//   Full      out  FIFO full
//   Err       out  sticky invalid-prefix flag
//   Sym_cnt   out  symbols decoded since Start (stats build only)
//   Err_cnt   out  invalid prefixes since Start (stats build only)
module huffman_decoder #(
  parameter int FIFO_AW = 2,
  parameter int CNT_W   = 16
) (
  input  logic             Clk_in,
  input  logic             n_Rst,
  input  logic             Start,
  input  logic             Bit_in,
  input  logic             Bit_vld,
  output logic             Bit_rdy,
  input  logic             Rd_en,
  output logic [3:0]       Data_out,
  output logic             Empty,
  output logic             Full,
  output logic             Err
`ifdef HUFFMAN_DEC_STATS_EN
  ,
  output logic [CNT_W-1:0] Sym_cnt,
  output logic [CNT_W-1:0] Err_cnt
`endif
);

  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_ERROR  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [3:0]       acc_q, acc_d;
  logic [2:0]       len_q, len_d;
  logic             err_q, err_d;
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]       mem_q [DEPTH];
  logic [3:0]       mem_d [DEPTH];

  logic       empty;
  logic       full;
  logic       bit_acc;
  logic       rd_do;
  logic [4:0] code;
  logic [2:0] new_len;
  logic       hit;
  logic       bad;
  logic [3:0] sym;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                 (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);

  assign Bit_rdy  = (state_q == ST_DECODE) && !full;
  assign Empty    = empty;
  assign Full     = full;
  assign Err      = err_q;
  assign Data_out = empty ? 4'd0 : mem_q[rd_ptr_q[FIFO_AW-1:0]];

  // Start takes priority over both the serial bit and the FIFO pop.
  assign bit_acc = Bit_vld && Bit_rdy && !Start;
  assign rd_do   = Rd_en && !empty && !Start;

  // Candidate codeword: stored partial bits plus the incoming bit, right-aligned.
  assign code    = {acc_q, Bit_in};
  assign new_len = len_q + 3'd1;

  always_comb begin
    hit = 1'b0;
    bad = 1'b0;
    sym = 4'd0;
    case (new_len)
      3'd2: if (code[1:0] == 2'b00) begin hit = 1'b1; sym = 4'd0; end
      3'd3: begin
        case (code[2:0])
          3'b010:  begin hit = 1'b1; sym = 4'd1; end
          3'b011:  begin hit = 1'b1; sym = 4'd4; end
          3'b100:  begin hit = 1'b1; sym = 4'd9; end
          default: ;
        endcase
      end
      3'd4: begin
        case (code[3:0])
          4'b1010: begin hit = 1'b1; sym = 4'd2; end
          4'b1011: begin hit = 1'b1; sym = 4'd5; end
          4'b1100: begin hit = 1'b1; sym = 4'd3; end
          4'b1101: begin hit = 1'b1; sym = 4'd7; end
          default: ;
        endcase
      end
      3'd5: begin
        // Only 1110x/1111x can reach five bits; anything else here is invalid.
        case (code)
          5'b11100: begin hit = 1'b1; sym = 4'd6; end
          5'b11101: begin hit = 1'b1; sym = 4'd8; end
          default:  bad = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    len_d    = len_q;
    err_d    = err_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (Start) begin
      state_d  = ST_DECODE;
      acc_d    = 4'd0;
      len_d    = 3'd0;
      err_d    = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (rd_do) rd_ptr_d = rd_ptr_q + 1'b1;
      if (bit_acc) begin
        if (hit) begin
          mem_d[wr_ptr_q[FIFO_AW-1:0]] = sym;
          wr_ptr_d = wr_ptr_q + 1'b1;
          acc_d    = 4'd0;
          len_d    = 3'd0;
        end else if (bad) begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
          acc_d   = 4'd0;
          len_d   = 3'd0;
        end else begin
          acc_d = code[3:0];
          len_d = new_len;
        end
      end
    end
  end

  always_ff @(posedge Clk_in or negedge n_Rst) begin
    if (!n_Rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= 4'd0;
      len_q    <= 3'd0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 4'd0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      len_q    <= len_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

`ifdef HUFFMAN_DEC_STATS_EN
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    sym_cnt_d = sym_cnt_q;
    err_cnt_d = err_cnt_q;
    if (Start) begin
      sym_cnt_d = '0;
      err_cnt_d = '0;
    end else if (bit_acc) begin
      if (hit && (sym_cnt_q != '1)) sym_cnt_d = sym_cnt_q + 1'b1;
      if (bad && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk_in or negedge n_Rst) begin
    if (!n_Rst) begin
      sym_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      sym_cnt_q <= sym_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign Sym_cnt = sym_cnt_q;
  assign Err_cnt = err_cnt_q;
`endif

endmodule
